// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Bundles the three buses around the data-memory arbiter.
//               Port A   : pipeline MEM stage (a_read/a_write/a_addr/a_wdata
//                          in, a_rdata/a_stall out).
//               Port B   : loader/debug requester (b_req/b_we/b_addr/b_wdata
//                          in, b_ack/b_rdata out).
//               Memory   : mem_addr/mem_wdata/mem_read/mem_write out,
//                          mem_rdata in (combinational read).
//               Status   : grant_b, starve_cnt out.
//               master   = arbiter view, slave = surrounding-system view.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
    parameter int DW = 32
);
    // Port A
    logic          a_read;
    logic          a_write;
    logic [DW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic [DW-1:0] a_rdata;
    logic          a_stall;
    // Port B
    logic          b_req;
    logic          b_we;
    logic [DW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_ack;
    logic [DW-1:0] b_rdata;
    // Data memory
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_rdata;
    // Status
    logic          grant_b;
    logic [3:0]    starve_cnt;

    modport master (
        input  a_read, a_write, a_addr, a_wdata,
        output a_rdata, a_stall,
        input  b_req, b_we, b_addr, b_wdata,
        output b_ack, b_rdata,
        output mem_addr, mem_wdata, mem_read, mem_write,
        input  mem_rdata,
        output grant_b, starve_cnt
    );

    modport slave (
        output a_read, a_write, a_addr, a_wdata,
        input  a_rdata, a_stall,
        output b_req, b_we, b_addr, b_wdata,
        input  b_ack, b_rdata,
        input  mem_addr, mem_wdata, mem_read, mem_write,
        output mem_rdata,
        input  grant_b, starve_cnt
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-port arbiter in front of a single-ported data memory.
//               Port A (pipeline) owns memory by default with zero added
//               latency. Port B (loader/debug) is granted one-cycle slots
//               whenever A is idle, or after B has waited STARVE_LIMIT
//               cycles behind an active A, in which case A is stalled for
//               that single cycle.
// Ports       : clk  - rising-edge clock
//               rst  - synchronous active-high reset
//               bus  - dmem_arbiter_if.master (port A, port B, memory,
//                      status signals)
// Parameters  : STARVE_LIMIT - B waiting cycles before preempting A (1..15)
//               DW           - data/address width
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int DW           = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    dmem_arbiter_if.master    bus
);

    localparam logic [0:0] c_a_own         = 1'b0;
    localparam logic [0:0] c_b_own         = 1'b1;
    localparam logic [3:0] c_starve_limit  = 4'(STARVE_LIMIT);

    logic [0:0]    r_state;
    logic [3:0]    r_starve_cnt;
    logic [DW-1:0] r_b_rdata;

    logic          w_a_active;
    logic          w_b_serve;

    // A read+write together counts as a write, but either makes A active.
    assign w_a_active = bus.a_read | bus.a_write;

    // B is actually served only in its slot, with a live request, out of reset.
    assign w_b_serve  = (r_state == c_b_own) && bus.b_req && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_a_own;
            r_starve_cnt <= 4'd0;
            r_b_rdata    <= '0;
        end else begin
            case (r_state)
                c_a_own: begin
                    if (bus.b_req && (!w_a_active || r_starve_cnt == c_starve_limit)) begin
                        r_state      <= c_b_own;
                        r_starve_cnt <= 4'd0;
                    end else if (bus.b_req) begin
                        if (r_starve_cnt != c_starve_limit) begin
                            r_starve_cnt <= r_starve_cnt + 4'd1;
                        end
                    end else begin
                        r_starve_cnt <= 4'd0;
                    end
                end
                default: begin
                    // B slot is always exactly one cycle long.
                    r_state <= c_a_own;
                    if (bus.b_req) begin
                        r_b_rdata <= bus.mem_rdata;
                    end
                end
            endcase
        end
    end

    always_comb begin
        bus.mem_addr  = bus.a_addr;
        bus.mem_wdata = bus.a_wdata;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.a_stall   = 1'b0;
        bus.a_rdata   = '0;
        bus.grant_b   = 1'b0;
        bus.b_ack     = w_b_serve;
        // b_rdata shows the live read in the ack cycle, else the last acked value.
        bus.b_rdata   = w_b_serve ? bus.mem_rdata : r_b_rdata;

        if (r_state == c_a_own) begin
            bus.mem_read  = bus.a_read & ~bus.a_write;
            bus.mem_write = bus.a_write;
            bus.a_rdata   = bus.mem_rdata;
        end else begin
            bus.mem_addr  = bus.b_addr;
            bus.mem_wdata = bus.b_wdata;
            bus.mem_read  = bus.b_req & ~bus.b_we;
            bus.mem_write = bus.b_req & bus.b_we;
            bus.a_stall   = w_a_active;
            bus.grant_b   = 1'b1;
        end

        // Reset suppresses every access and handshake in the same cycle.
        if (rst) begin
            bus.mem_read  = 1'b0;
            bus.mem_write = 1'b0;
            bus.a_stall   = 1'b0;
            bus.grant_b   = 1'b0;
        end
    end

    assign bus.starve_cnt = r_starve_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Randomized self-checking bench for dmem_arbiter. A small
//               word memory is attached to the memory port; a protocol-level
//               reference keeps its own copy of memory contents, B's waiting
//               time and whether the current cycle is B's slot.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int LIMIT = 4;
    localparam int NCYC  = 4000;

    logic clk;
    logic rst;

    dmem_arbiter_if #(.DW(32)) bus ();

    dmem_arbiter #(
        .STARVE_LIMIT (LIMIT),
        .DW           (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical memory seen by the DUT: 16 words addressed by addr[5:2].
    logic [31:0] dev_mem [16];
    assign bus.mem_rdata = dev_mem[bus.mem_addr[5:2]];
    always @(posedge clk) begin
        if (bus.mem_write) dev_mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference state
    logic [31:0] ref_mem [16];
    bit          ref_b_slot;
    int          ref_wait;
    logic [31:0] ref_last_b;

    // Driver bookkeeping
    bit a_hold;
    bit b_pending;
    int b_age;

    initial begin
        int phase;
        int a_pct;
        int b_pct;
        bit a_act;
        bit e_grant, e_stall, e_ack, e_mr, e_mw;
        logic [31:0] e_addr, e_wdata, e_ardata, e_brdata;
        logic [3:0]  ai, bi;

        for (int i = 0; i < 16; i++) begin
            dev_mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        ref_b_slot = 1'b0;
        ref_wait   = 0;
        ref_last_b = 32'h0;
        a_hold     = 1'b0;
        b_pending  = 1'b0;
        b_age      = 0;

        rst         = 1'b1;
        bus.a_read  = 1'b0;
        bus.a_write = 1'b0;
        bus.a_addr  = 32'h0;
        bus.a_wdata = 32'h0;
        bus.b_req   = 1'b0;
        bus.b_we    = 1'b0;
        bus.b_addr  = 32'h0;
        bus.b_wdata = 32'h0;
        @(posedge clk);

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            phase = cyc / 1000;
            case (phase)
                0:       begin a_pct = 100; b_pct = 60; end  // B must preempt a busy A
                1:       begin a_pct = 30;  b_pct = 50; end  // A mostly idle
                2:       begin a_pct = 80;  b_pct = 40; end  // withdrawals
                default: begin a_pct = 60;  b_pct = 50; end  // random resets
            endcase

            if (cyc < 2)         rst = 1'b1;
            else if (phase == 3) rst = ($urandom_range(0, 15) == 0);
            else                 rst = 1'b0;

            if (!a_hold) begin
                if ($urandom_range(0, 99) < a_pct) begin
                    case ($urandom_range(0, 2))
                        0:       begin bus.a_read = 1'b1; bus.a_write = 1'b0; end
                        1:       begin bus.a_read = 1'b0; bus.a_write = 1'b1; end
                        default: begin bus.a_read = 1'b1; bus.a_write = 1'b1; end
                    endcase
                end else begin
                    bus.a_read  = 1'b0;
                    bus.a_write = 1'b0;
                end
                bus.a_addr  = $urandom;
                bus.a_wdata = $urandom;
            end

            if (b_pending) begin
                if (phase == 2 && $urandom_range(0, 3) == 0) begin
                    bus.b_req = 1'b0;
                    b_pending = 1'b0;
                    b_age     = 0;
                end
            end else begin
                bus.b_req   = ($urandom_range(0, 99) < b_pct);
                bus.b_we    = $urandom_range(0, 1);
                bus.b_addr  = $urandom;
                bus.b_wdata = $urandom;
                b_age       = 0;
            end

            #2;
            a_act = bus.a_read | bus.a_write;
            ai    = bus.a_addr[5:2];
            bi    = bus.b_addr[5:2];

            if (ref_b_slot) begin
                e_grant  = 1'b1;
                e_stall  = a_act;
                e_ack    = bus.b_req;
                e_mw     = bus.b_req & bus.b_we;
                e_mr     = bus.b_req & ~bus.b_we;
                e_addr   = bus.b_addr;
                e_wdata  = bus.b_wdata;
                e_ardata = 32'h0;
            end else begin
                e_grant  = 1'b0;
                e_stall  = 1'b0;
                e_ack    = 1'b0;
                e_mw     = bus.a_write;
                e_mr     = bus.a_read & ~bus.a_write;
                e_addr   = bus.a_addr;
                e_wdata  = bus.a_wdata;
                e_ardata = ref_mem[ai];
            end
            if (rst) begin
                e_grant = 1'b0;
                e_stall = 1'b0;
                e_ack   = 1'b0;
                e_mw    = 1'b0;
                e_mr    = 1'b0;
            end
            e_brdata = e_ack ? ref_mem[bi] : ref_last_b;

            check("grant_b",    bus.grant_b,    e_grant);
            check("a_stall",    bus.a_stall,    e_stall);
            check("b_ack",      bus.b_ack,      e_ack);
            check("mem_read",   bus.mem_read,   e_mr);
            check("mem_write",  bus.mem_write,  e_mw);
            check("starve_cnt", bus.starve_cnt, 32'(ref_wait));
            check("a_rdata",    bus.a_rdata,    e_ardata);
            check("b_rdata",    bus.b_rdata,    e_brdata);
            if (e_mr || e_mw) check("mem_addr",  bus.mem_addr,  e_addr);
            if (e_mw)         check("mem_wdata", bus.mem_wdata, e_wdata);
            if (e_ack)        check("b_latency", 32'(b_age <= LIMIT + 1), 32'd1);

            // Advance the reference by one clock.
            if (rst) begin
                ref_b_slot = 1'b0;
                ref_wait   = 0;
                ref_last_b = 32'h0;
            end else if (ref_b_slot) begin
                if (bus.b_req) begin
                    ref_last_b = ref_mem[bi];
                    if (bus.b_we) ref_mem[bi] = bus.b_wdata;
                end
                ref_b_slot = 1'b0;
            end else begin
                if (bus.a_write) ref_mem[ai] = bus.a_wdata;
                if (bus.b_req && (!a_act || ref_wait == LIMIT)) begin
                    ref_b_slot = 1'b1;
                    ref_wait   = 0;
                end else if (bus.b_req) begin
                    ref_wait = (ref_wait < LIMIT) ? ref_wait + 1 : LIMIT;
                end else begin
                    ref_wait = 0;
                end
            end

            a_hold    = e_stall;
            b_pending = bus.b_req && !e_ack && !rst;
            b_age     = b_pending ? b_age + 1 : 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, the number of consecutive waiting cycles of port B before B preempts port A (range 1..15).
REQ-002 SHALL have parameter DW, default 32, the data and address width.
REQ-003 SHALL have one clock; reset is synchronous and active-high; ports: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-004 Port A (pipeline MEM stage) SHALL have these ports: a_read in 1; a_write in 1; a_addr in DW; a_wdata in DW; a_rdata out DW; a_stall out 1, which freezes the pipeline.
REQ-005 Port B (loader/debug) SHALL have these ports: b_req in 1; b_we in 1; b_addr in DW; b_wdata in DW; b_ack out 1, a one-cycle completion pulse; b_rdata out DW.
REQ-006 The data-memory port SHALL have these ports: mem_addr out DW; mem_wdata out DW; mem_read out 1; mem_write out 1; mem_rdata in DW, a combinational read within the same cycle.
REQ-007 Status SHALL have these ports: grant_b out 1, high while B owns memory; starve_cnt out 4.

Function
REQ-008 SHALL implement a two-state FSM: A_OWN, the default, and B_OWN.
REQ-009 In A_OWN, the memory port SHALL be driven from port A as follows.
- mem_addr=a_addr, mem_wdata=a_wdata, mem_write=a_write, mem_read=a_read&~a_write.
- a_stall=0, grant_b=0, b_ack=0.
REQ-010 In A_OWN, a_rdata SHALL equal mem_rdata in the same cycle (zero added latency).
REQ-011 a_read and a_write both high SHALL be treated as a write; mem_read=0.
REQ-012 The A-active condition SHALL be a_read|a_write.
REQ-013 In A_OWN with b_req=1 and A active, starve_cnt SHALL increment at the clock edge, saturating at STARVE_LIMIT.
REQ-014 In A_OWN with b_req=0, starve_cnt SHALL clear to 0 at the clock edge.
REQ-015 A_OWN SHALL transition to B_OWN at the clock edge when b_req=1 and either A is inactive or starve_cnt==STARVE_LIMIT.
- starve_cnt SHALL clear to 0 on that transition.
REQ-016 In B_OWN, the memory port SHALL be driven from port B as follows.
- mem_addr=b_addr, mem_wdata=b_wdata, mem_write=b_req&b_we, mem_read=b_req&~b_we.
- grant_b=1.
REQ-017 In B_OWN, a_stall SHALL equal a_read|a_write, and no port-A access SHALL reach memory.
REQ-018 In B_OWN, b_ack SHALL be high for exactly that cycle when b_req=1, and b_rdata SHALL equal mem_rdata in that cycle.
REQ-019 If b_req=0 in B_OWN (request withdrawn), there SHALL be no memory access and no b_ack.
REQ-020 B_OWN SHALL last exactly one cycle and always return to A_OWN.
- Port A is therefore guaranteed at least one A_OWN cycle between consecutive B accesses.
REQ-021 b_rdata SHALL hold its last acked value outside b_ack cycles; a_rdata SHALL track mem_rdata only in A_OWN and be 0 in B_OWN.
REQ-022 Requesters SHALL hold request, address and data stable until served: A until a_stall=0, B until b_ack.
REQ-023 Maximum B wait from b_req rise to b_ack SHALL be STARVE_LIMIT+1 cycles.

Reset
REQ-024 On rst=1 at a clock edge, the following SHALL be set: state=A_OWN, starve_cnt=0, b_rdata=0.
REQ-025 While rst is high, the combinational outputs SHALL be: b_ack=0, grant_b=0, a_stall=0, mem_read=0, mem_write=0.
REQ-026 Reset asserted during B_OWN SHALL abort the access with no b_ack and no mem_write in that cycle.
REQ-027 Reset SHALL take precedence over every FSM transition.

Verification
REQ-028 Idle B: a_read=1, a_addr=0x10, b_req=0 for 10 cycles -> mem_read=1, mem_addr=0x10 every cycle; a_stall=0; starve_cnt=0.
REQ-029 B with A idle: b_req=1, b_we=1, b_addr=0x40, b_wdata=0xDEADBEEF, A inactive -> next cycle grant_b=1, mem_write=1, b_ack=1; a later B read of 0x40 returns b_rdata=0xDEADBEEF.
REQ-030 Starvation: A writes continuously and b_req=1 from cycle 0 with STARVE_LIMIT=4 -> starve_cnt=1,2,3,4; b_ack in cycle 5; a_stall=1 in cycle 5 only; A resumes in cycle 6 with a_stall=0.
REQ-031 Withdrawal: b_req=1 for 2 cycles under A load then 0 -> starve_cnt returns to 0; no b_ack; no B_OWN entry.
REQ-032 Reset mid-grant: rst=1 in the B_OWN cycle -> b_ack=0, mem_write=0, next state A_OWN, starve_cnt=0.
REQ-033 Simultaneous a_read=a_write=1 with a_addr=0x8 -> mem_write=1, mem_read=0.
